// File: rtl/lcd_msg_seq_pkg.sv
// Shared definitions for the LCD message sequencer: FSM state encoding,
// HD44780-style DDRAM address commands and the blank character.
package lcd_msg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LINE0_CMD = 3'd1,
        LINE0_CHR = 3'd2,
        LINE1_CMD = 3'd3,
        LINE1_CHR = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [7:0] LCD_CMD_LINE0  = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1  = 8'hC0;
    localparam logic [7:0] LCD_CHAR_BLANK = 8'h20;

    // Flat buffer index for a (line, column) pair.
    function automatic logic [4:0] buf_index(input logic line, input logic [4:0] col,
                                             input logic [4:0] cols);
        return line ? (cols + col) : col;
    endfunction

endpackage

// File: rtl/lcd_refresh_tick.sv
// Free-running refresh divider: counts 0..REFRESH_DIV-1 and wraps,
// raising tick for the single cycle the terminal count is held.
module lcd_refresh_tick #(
    parameter int REFRESH_DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap to zero after the terminal count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TERM) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/lcd_msg_seq.sv
// LCD message sequencer: holds a 2-line character buffer written by a host
// and, on every refresh tick, streams one frame of driver words
// (line-0 address command, COLS characters, line-1 address command,
// COLS characters) over a valid/ready handshake.
// Optional build macro LCD_MSG_SEQ_DIRTY_EN: only refresh when the buffer
// has been written since the last frame started.
module lcd_msg_seq
    import lcd_msg_seq_pkg::*;
#(
    parameter int REFRESH_DIV = 10000,
    parameter int COLS        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int         NCHR  = 2 * COLS;
    localparam logic [4:0] COLS5 = 5'(COLS);
    localparam logic [4:0] LAST  = 5'(COLS - 1);

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic [NCHR-1:0][7:0] char_q, char_d;
    logic                 wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < 6'(NCHR));

    // Host write port; out-of-range addresses are dropped.
    always_comb begin
        char_d = char_q;
        if (wr_ok) char_d[wr_addr] = wr_char;
    end

    // Buffer storage, cleared to blanks on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) char_q <= {NCHR{LCD_CHAR_BLANK}};
        else     char_q <= char_d;
    end

    // ------------------------------------------------------------------
    // Refresh tick
    // ------------------------------------------------------------------
    logic tick;

    lcd_refresh_tick #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // ------------------------------------------------------------------
    // Frame gating
    // ------------------------------------------------------------------
    logic start_ok;
    logic frame_start;

`ifdef LCD_MSG_SEQ_DIRTY_EN
    logic dirty_q, dirty_d;

    // A write wins over the clear so a write landing on the frame-start
    // cycle still schedules another refresh.
    always_comb begin
        dirty_d = dirty_q;
        if (frame_start) dirty_d = 1'b0;
        if (wr_ok)       dirty_d = 1'b1;
    end

    // Dirty flag; set out of reset so the first tick paints the blanks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dirty_q <= 1'b1;
        else     dirty_q <= dirty_d;
    end

    assign start_ok = dirty_q;
`else
    assign start_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame FSM with registered output word
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic       ov_q, ov_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       accept;
    logic [4:0] col_nxt;

    assign accept  = ov_q && out_ready;
    assign col_nxt = col_q + 5'd1;

    // Next state and next presented word. The character byte is captured
    // into data_q when its word is first presented, so later host writes
    // (including one on the same edge) cannot disturb a held word.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        ov_d        = ov_q;
        rs_d        = rs_q;
        data_d      = data_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && start_ok) begin
                    state_d     = LINE0_CMD;
                    col_d       = '0;
                    ov_d        = 1'b1;
                    rs_d        = 1'b0;
                    data_d      = LCD_CMD_LINE0;
                    frame_start = 1'b1;
                end
            end
            LINE0_CMD: begin
                if (accept) begin
                    state_d = LINE0_CHR;
                    col_d   = '0;
                    rs_d    = 1'b1;
                    data_d  = char_q[buf_index(1'b0, 5'd0, COLS5)];
                end
            end
            LINE0_CHR: begin
                if (accept) begin
                    if (col_q == LAST) begin
                        state_d = LINE1_CMD;
                        col_d   = '0;
                        rs_d    = 1'b0;
                        data_d  = LCD_CMD_LINE1;
                    end else begin
                        col_d  = col_nxt;
                        data_d = char_q[buf_index(1'b0, col_nxt, COLS5)];
                    end
                end
            end
            LINE1_CMD: begin
                if (accept) begin
                    state_d = LINE1_CHR;
                    col_d   = '0;
                    rs_d    = 1'b1;
                    data_d  = char_q[buf_index(1'b1, 5'd0, COLS5)];
                end
            end
            LINE1_CHR: begin
                if (accept) begin
                    if (col_q == LAST) begin
                        state_d = DONE;
                        col_d   = '0;
                        ov_d    = 1'b0;
                        rs_d    = 1'b0;
                        data_d  = 8'h00;
                    end else begin
                        col_d  = col_nxt;
                        data_d = char_q[buf_index(1'b1, col_nxt, COLS5)];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
                rs_d    = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

    // FSM, column and output word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            ov_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ov_q    <= ov_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_rs     = rs_q;
    assign out_data   = data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_lcd_msg_seq.sv
// Directed bench for lcd_msg_seq (REFRESH_DIV=64, COLS=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lcd_msg_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic       out_valid;
    logic       out_ready;
    logic       out_rs;
    logic [7:0] out_data;
    logic       busy;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mdl  [32];
    logic [7:0] snap [32];
    logic [8:0] got  [34];

    lcd_msg_seq #(.REFRESH_DIV(64), .COLS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_char   (wr_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rs    (out_rs),
        .out_data  (out_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        step();
        wr_en = 1'b0;
        mdl[a] = c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    endtask

    task automatic take_snap();
        for (int i = 0; i < 32; i++) snap[i] = mdl[i];
    endtask

    // Expected {rs,data} of frame word i (0-based) from the snapshot.
    function automatic logic [8:0] exp_word(input int i);
        if (i == 0)  return {1'b0, 8'h80};
        if (i <= 16) return {1'b1, snap[i-1]};
        if (i == 17) return {1'b0, 8'hC0};
        return {1'b1, snap[16 + (i - 18)]};
    endfunction

    // Wait for a frame and collect 34 accepted words; optionally stall on
    // word stall_at for stall_n cycles while writing waddr/wchar.
    task automatic collect(input string name, input int stall_at, input int stall_n,
                           input logic [4:0] waddr, input logic [7:0] wchar,
                           output int waited);
        int n, cyc;
        logic [8:0] hold;
        waited = 0;
        while (!out_valid && waited < 300) begin step(); waited++; end
        chk({name, " start within bound"}, 32'(waited < 300), 1);
        n = 0; cyc = 0;
        while (n < 34 && cyc < 400) begin
            if (n == stall_at && stall_n > 0 && out_valid) begin
                hold = {out_rs, out_data};
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    if (s == 0) begin wr_en = 1'b1; wr_addr = waddr; wr_char = wchar; end
                    step();
                    wr_en = 1'b0;
                    cyc++;
                    chk($sformatf("%s stall hold %0d", name, s),
                        {23'd0, out_valid, out_rs, out_data}, {23'd0, 1'b1, hold});
                end
                out_ready = 1'b1;
                stall_at = -1;
            end
            if (out_valid && out_ready) begin got[n] = {out_rs, out_data}; n++; end
            step();
            cyc++;
        end
        chk({name, " word count"}, 32'(n), 34);
        chk({name, " cycles (no bubbles)"}, 32'(cyc), 32'(34 + stall_n));
        chk({name, " done state {fd,valid,busy}"}, {29'd0, frame_done, out_valid, busy}, 32'b101);
        step();
        chk({name, " back to idle {fd,busy}"}, {30'd0, frame_done, busy}, 32'b00);
        for (int i = 0; i < 34; i++)
            chk($sformatf("%s word %0d", name, i), {23'd0, got[i]}, {23'd0, exp_word(i)});
    endtask

    initial begin
        int w, n, g;
        logic seen;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0; out_ready = 1'b1;
        model_reset();

        // Reset state
        step(); step(); step();
        chk("reset out_valid", {31'd0, out_valid}, 0);
        chk("reset out_rs", {31'd0, out_rs}, 0);
        chk("reset out_data", {24'd0, out_data}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset frame_done", {31'd0, frame_done}, 0);

        // First tick lands 64 edges after release
        rst = 1'b0;
        repeat (63) step();
        chk("pre-tick idle {valid,busy}", {30'd0, out_valid, busy}, 0);
        step();
        chk("first word {valid,rs,data}", {23'd0, out_valid, out_rs, out_data}, {23'd0, 1'b1, 1'b0, 8'h80});

        // Blank frame
        take_snap();
        collect("blank", -1, 0, 5'd0, 8'h00, w);

        // Host text on both lines
        host_write(5'd0, 8'h48);
        host_write(5'd17, 8'h69);
        take_snap();
        collect("text", -1, 0, 5'd0, 8'h00, w);
        chk("text word 1 (H)", {23'd0, got[1]}, {23'd0, 1'b1, 8'h48});
        chk("text word 19 (i)", {23'd0, got[19]}, {23'd0, 1'b1, 8'h69});

        // Back-pressure on word index 2 while rewriting its address
        host_write(5'd31, 8'h78);
        take_snap();
        collect("stall", 2, 5, 5'd1, 8'h5A, w);
        mdl[1] = 8'h5A;
        chk("stall word 2 pre-write", {23'd0, got[2]}, {23'd0, 1'b1, 8'h20});

        // The rewritten character shows on the next frame
        take_snap();
        collect("after stall", -1, 0, 5'd0, 8'h00, w);
        chk("after stall word 2", {23'd0, got[2]}, {23'd0, 1'b1, 8'h5A});

        // Reset in the middle of a frame
        host_write(5'd5, 8'h35);
        g = 0;
        while (!out_valid && g < 300) begin step(); g++; end
        n = 0;
        while (n < 10 && g < 600) begin
            if (out_valid && out_ready) n++;
            step(); g++;
        end
        chk("abort reached word 10", 32'(n), 10);
        rst = 1'b1;
        #1;
        chk("abort {valid,busy,fd}", {29'd0, out_valid, busy, frame_done}, 0);
        step();
        rst = 1'b0;
        model_reset();
        take_snap();
        collect("post-reset", -1, 0, 5'd0, 8'h00, w);
        chk("post-reset start latency", 32'(w), 64);

`ifdef LCD_MSG_SEQ_DIRTY_EN
        // Clean buffer: ticks pass without a frame
        seen = 1'b0;
        repeat (140) begin step(); if (busy || out_valid) seen = 1'b1; end
        chk("clean buffer no frame", {31'd0, seen}, 0);
        host_write(5'd3, 8'h41);
        take_snap();
        collect("dirty frame", -1, 0, 5'd0, 8'h00, w);
`else
        // Every tick refreshes even without writes
        seen = 1'b0;
        take_snap();
        collect("unchanged frame", -1, 0, 5'd0, 8'h00, w);
        chk("unchanged frame start <= one period", 32'(w <= 64), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_msg_seq.md
LCD_MSG_SEQ -- requirements
Module: lcd_msg_seq

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 10000, meaning clk cycles between frame-refresh starts (minimum 64).
REQ-002 SHALL have parameter COLS, default 16, meaning characters per LCD line (2 lines fixed).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit, host character-write strobe.
REQ-006 SHALL have port wr_addr, input, 5 bits, buffer index: 0..COLS-1 is line 0, COLS..2*COLS-1 is line 1.
REQ-007 SHALL have port wr_char, input, 8 bits, ASCII code to store.
REQ-008 SHALL have port out_valid, output, 1 bit, a driver word is presented.
REQ-009 SHALL have port out_ready, input, 1 bit, the driver accepts the word this cycle.
REQ-010 SHALL have port out_rs, output, 1 bit, 0 = command, 1 = character data.
REQ-011 SHALL have port out_data, output, 8 bits, the command or character byte.
REQ-012 SHALL have port busy, output, 1 bit, high while a frame is being streamed.
REQ-013 SHALL have port frame_done, output, 1 bit, one-cycle pulse at frame end.

Function
REQ-014 SHALL hold a 2*COLS x 8-bit character buffer; wr_en writes wr_char at wr_addr on the clock edge; wr_addr >= 2*COLS SHALL be ignored.
REQ-015 SHALL run a free-running refresh counter 0..REFRESH_DIV-1 that wraps and asserts a start tick on its terminal count.
REQ-016 SHALL use FSM states IDLE, LINE0_CMD, LINE0_CHR, LINE1_CMD, LINE1_CHR, DONE.
REQ-017 In IDLE, on a start tick, SHALL go to LINE0_CMD; a tick arriving outside IDLE SHALL be dropped.
REQ-018 LINE0_CMD SHALL present out_rs=0, out_data=0x80; LINE1_CMD SHALL present out_rs=0, out_data=0xC0.
REQ-019 LINEn_CHR SHALL present out_rs=1 and buffer[n*COLS+col], col running 0..COLS-1, advancing one column per accepted word.
REQ-020 A word SHALL be accepted only when out_valid and out_ready are both high; out_valid, out_rs, and out_data SHALL remain stable until acceptance.
REQ-021 The character byte SHALL be sampled from the buffer when the word is first presented; a write to the same address while the word is held SHALL NOT alter it.
REQ-022 After acceptance of LINE1_CHR col COLS-1, SHALL enter DONE for one cycle with frame_done=1 and out_valid=0, then return to IDLE.
REQ-023 One frame SHALL be exactly 2*COLS+2 accepted words (34 at default).
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 With out_ready held high, consecutive words SHALL be accepted on consecutive cycles with no bubbles.
REQ-026 A host write and a streamed read of the same address in one cycle SHALL present the old value.

Reset
REQ-027 While rst is high, SHALL force: FSM=IDLE, col=0, refresh counter=0, out_valid=0, out_rs=0, out_data=0x00, busy=0, frame_done=0, and all buffer entries=0x20 (space).
REQ-028 Reset asserted mid-frame SHALL abort immediately; the first frame after release SHALL start at LINE0_CMD on the next start tick.

Configuration
REQ-029 Macro LCD_MSG_SEQ_DIRTY_EN: when defined, SHALL track a dirty flag, set by any valid write and cleared on entry to LINE0_CMD, and a start tick SHALL begin a frame only if dirty=1; a write during a frame SHALL set it again.
REQ-030 Without LCD_MSG_SEQ_DIRTY_EN, every start tick in IDLE SHALL begin a frame; reset SHALL set dirty=1 when the macro is defined.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, LCD_CMD_LINE0=0x80, LCD_CMD_LINE1=0xC0, and LCD_CHAR_BLANK=0x20.
REQ-032 SHALL instantiate one sub-module, lcd_refresh_tick, containing the REFRESH_DIV counter and tick output.

Verification
REQ-033 Reset, REFRESH_DIV=64, out_ready=1 -> at the first tick, 34 words: 0x80, sixteen 0x20, 0xC0, sixteen 0x20; then one frame_done pulse.
REQ-034 Write 'H'(0x48) at address 0 and 'i'(0x69) at address 17, then let a frame run -> word 2=0x48/rs=1 and word 20=0x69/rs=1.
REQ-035 Hold out_ready=0 for 5 cycles on word 3 while writing address 1 -> word 3 stays stable and keeps its pre-write value; words are neither lost nor duplicated.
REQ-036 Assert rst at word 10 -> out_valid=0 and busy=0 immediately; the next frame starts with 0x80.
REQ-037 With LCD_MSG_SEQ_DIRTY_EN defined, after one frame and no writes -> the next tick starts no frame; a single write -> the following tick streams a full frame.
